// File: rtl/game_pkg.sv
// Shared definitions for the runner game: state encoding, BCD digit type and speed-ramp defaults.
package game_pkg;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_RUN   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_OVER  = 3'd4
  } game_state_e;

  localparam int unsigned DIFF_W        = 7;
  localparam int unsigned SCORE_W       = 16;
  localparam int unsigned DIFF_INIT_DEF = 60;
  localparam int unsigned DIFF_MIN_DEF  = 20;
  localparam int unsigned DIFF_STEP_DEF = 4;

  // Digit-wise BCD magnitude compare starting at the most significant digit.
  function automatic logic bcd_gt(input logic [SCORE_W-1:0] a, input logic [SCORE_W-1:0] b);
    bcd_digit_t a3, a2, a1, a0, b3, b2, b1, b0;
    logic gt;
    {a3, a2, a1, a0} = a;
    {b3, b2, b1, b0} = b;
    if (a3 != b3)      gt = (a3 > b3);
    else if (a2 != b2) gt = (a2 > b2);
    else if (a1 != b1) gt = (a1 > b1);
    else               gt = (a0 > b0);
    return gt;
  endfunction

endpackage

// File: rtl/bcd_counter4.sv
// 4-digit BCD counter that saturates at 9999; clear has priority over inc.
module bcd_counter4
  import game_pkg::*;
(
  input  logic               clk_100ms,
  input  logic               reset,
  input  logic               clear,
  input  logic               inc,
  output logic [SCORE_W-1:0] count
);

  bcd_digit_t d3, d2, d1, d0;
  logic [SCORE_W-1:0] count_nx;

  assign {d3, d2, d1, d0} = count;

  // Incremented value with the carry rippling through all digits in one cycle.
  always_comb begin
    count_nx = count;
    if (count != 16'h9999) begin
      if (d0 != 4'd9) begin
        count_nx[3:0] = d0 + 4'd1;
      end else begin
        count_nx[3:0] = 4'd0;
        if (d1 != 4'd9) begin
          count_nx[7:4] = d1 + 4'd1;
        end else begin
          count_nx[7:4] = 4'd0;
          if (d2 != 4'd9) begin
            count_nx[11:8] = d2 + 4'd1;
          end else begin
            count_nx[11:8]  = 4'd0;
            count_nx[15:12] = d3 + 4'd1;
          end
        end
      end
    end
  end

  // Count register.
  always_ff @(posedge clk_100ms) begin
    if (reset || clear) begin
      count <= '0;
    end else if (inc) begin
      count <= count_nx;
    end
  end

endmodule

// File: rtl/game_flow_ctrl.sv
// Game sequencer: conditions buttons/collision, runs the game FSM, speed ramp, score and high score.
module game_flow_ctrl
  import game_pkg::*;
#(
  parameter int unsigned DIFF_INIT  = DIFF_INIT_DEF,
  parameter int unsigned DIFF_MIN   = DIFF_MIN_DEF,
  parameter int unsigned DIFF_STEP  = DIFF_STEP_DEF,
  parameter int unsigned RAMP_TICKS = 50,
  parameter int unsigned CLR_TICKS  = 2,
  parameter int unsigned OVER_HOLD  = 30
) (
  input  logic               clk_100ms,
  input  logic               reset,
  input  logic               btn_start,
  input  logic               btn_pause,
  input  logic               btn_jump,
  input  logic               collision,
  output logic               shut,
  output logic               clr,
  output logic               jump_en,
  output logic [DIFF_W-1:0]  diff,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] hi_score,
  output logic [2:0]         state,
  output logic               over
);

  localparam int unsigned RAMP_W = $clog2(RAMP_TICKS + 1);
  localparam int unsigned CLR_W  = $clog2(CLR_TICKS + 1);
  localparam int unsigned HOLD_W = $clog2(OVER_HOLD + 1);

  // Input bit order: 0 start, 1 pause, 2 jump, 3 collision.
  logic [3:0] sync1_q, sync2_q;
  logic [1:0] hist_q;
  logic       start_edge, pause_edge, jump_sync, coll_sync;

  game_state_e state_q, state_d;
  logic        shut_d, clr_d, over_d, jump_d;
  logic        enter_clear, enter_over, run_stay, ramp_wrap;
  logic [DIFF_W-1:0] diff_step;
  logic [RAMP_W-1:0] ramp_q;
  logic [CLR_W-1:0]  clr_cnt_q;
  logic [HOLD_W-1:0] hold_q;

  // Two-flop synchronizers plus a history flop on the two edge-triggered buttons.
  always_ff @(posedge clk_100ms) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      hist_q  <= '0;
    end else begin
      sync1_q <= {collision, btn_jump, btn_pause, btn_start};
      sync2_q <= sync1_q;
      hist_q  <= sync2_q[1:0];
    end
  end

  assign start_edge = sync2_q[0] & ~hist_q[0];
  assign pause_edge = sync2_q[1] & ~hist_q[1];
  assign jump_sync  = sync2_q[2];
  assign coll_sync  = sync2_q[3];

  // FSM state register.
  always_ff @(posedge clk_100ms) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and next-state-decoded outputs; collision wins over a pause edge in RUN.
  always_comb begin
    state_d = state_q;
    shut_d  = 1'b1;
    clr_d   = 1'b0;
    over_d  = 1'b0;
    jump_d  = 1'b0;
    case (state_q)
      ST_IDLE:  if (start_edge) state_d = ST_CLEAR;
      ST_CLEAR: if (clr_cnt_q == CLR_W'(CLR_TICKS - 1)) state_d = ST_RUN;
      ST_RUN: begin
        if (coll_sync)       state_d = ST_OVER;
        else if (pause_edge) state_d = ST_PAUSE;
      end
      ST_PAUSE: if (pause_edge) state_d = ST_RUN;
      ST_OVER:  if (start_edge && hold_q == HOLD_W'(OVER_HOLD - 1)) state_d = ST_CLEAR;
      default:  state_d = ST_IDLE;
    endcase
    case (state_d)
      ST_IDLE:  begin shut_d = 1'b1; clr_d = 1'b1; end
      ST_CLEAR: begin shut_d = 1'b0; clr_d = 1'b1; end
      ST_RUN:   begin shut_d = 1'b0; end
      ST_PAUSE: begin shut_d = 1'b1; end
      ST_OVER:  begin shut_d = 1'b1; over_d = 1'b1; end
      default:  begin shut_d = 1'b1; clr_d = 1'b1; end
    endcase
    jump_d = jump_sync && (state_d == ST_RUN);
  end

  assign enter_clear = (state_d == ST_CLEAR) && (state_q != ST_CLEAR);
  assign enter_over  = (state_d == ST_OVER)  && (state_q != ST_OVER);
  assign run_stay    = (state_q == ST_RUN)   && (state_d == ST_RUN);
  assign ramp_wrap   = (ramp_q == RAMP_W'(RAMP_TICKS - 1));
  assign diff_step   = (diff < DIFF_W'(DIFF_MIN + DIFF_STEP)) ? DIFF_W'(DIFF_MIN)
                                                               : diff - DIFF_W'(DIFF_STEP);

  // Registered outputs, speed ramp, CLEAR/OVER counters and high-score capture.
  always_ff @(posedge clk_100ms) begin
    if (reset) begin
      shut      <= 1'b1;
      clr       <= 1'b1;
      over      <= 1'b0;
      jump_en   <= 1'b0;
      diff      <= DIFF_W'(DIFF_INIT);
      ramp_q    <= '0;
      clr_cnt_q <= '0;
      hold_q    <= '0;
      hi_score  <= '0;
    end else begin
      shut    <= shut_d;
      clr     <= clr_d;
      over    <= over_d;
      jump_en <= jump_d;
      if (enter_clear) begin
        clr_cnt_q <= '0;
        diff      <= DIFF_W'(DIFF_INIT);
        ramp_q    <= '0;
      end else if (state_q == ST_CLEAR) begin
        clr_cnt_q <= clr_cnt_q + CLR_W'(1);
      end
      // Ramp only advances on cycles that stay in RUN, so a wrap coinciding with a collision is dropped.
      if (run_stay) begin
        if (ramp_wrap) begin
          ramp_q <= '0;
          diff   <= diff_step;
        end else begin
          ramp_q <= ramp_q + RAMP_W'(1);
        end
      end
      if (enter_over) begin
        hold_q <= '0;
        if (bcd_gt(score, hi_score)) hi_score <= score;
      end else if (state_q == ST_OVER && hold_q != HOLD_W'(OVER_HOLD - 1)) begin
        hold_q <= hold_q + HOLD_W'(1);
      end
    end
  end

  // Score counts only on cycles that stay in RUN; cleared on entry to CLEAR.
  bcd_counter4 u_score (
    .clk_100ms (clk_100ms),
    .reset     (reset),
    .clear     (enter_clear),
    .inc       (run_stay),
    .count     (score)
  );

  assign state = state_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Self-checking bench for game_flow_ctrl: per-cycle scoreboard against a behavioural model plus directed checks.
module tb_game_flow_ctrl;

  logic        clk_100ms = 1'b0;
  logic        reset = 1'b1;
  logic        btn_start = 1'b0, btn_pause = 1'b0, btn_jump = 1'b0, collision = 1'b0;
  logic        shut, clr, jump_en, over;
  logic [6:0]  diff;
  logic [15:0] score, hi_score;
  logic [2:0]  state;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int st; bit shut; bit clr; bit jmp; bit ovr; int diff; int score; int hi;
  } exp_t;
  exp_t exp_q[$];

  // Behavioural model state
  int m_st, m_cc, m_ramp, m_hold, m_score, m_hi, m_diff;
  bit m_shut, m_clr, m_jmp, m_ovr;
  logic [3:0] m_s1, m_s2;
  logic [1:0] m_h;

  game_flow_ctrl dut (
    .clk_100ms (clk_100ms), .reset (reset),
    .btn_start (btn_start), .btn_pause (btn_pause), .btn_jump (btn_jump), .collision (collision),
    .shut (shut), .clr (clr), .jump_en (jump_en), .diff (diff),
    .score (score), .hi_score (hi_score), .state (state), .over (over)
  );

  always #5 clk_100ms = ~clk_100ms;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] to_bcd(input int v);
    return 32'(((v / 1000) % 10) << 12 | ((v / 100) % 10) << 8 | ((v / 10) % 10) << 4 | (v % 10));
  endfunction

  // One model clock edge with the given inputs sampled.
  task automatic model_step(input bit rst, input logic [3:0] inp);
    int ns, nd;
    bit st_e, pa_e;
    if (rst) begin
      m_st = 0; m_cc = 0; m_ramp = 0; m_hold = 0; m_score = 0; m_hi = 0; m_diff = 60;
      m_shut = 1; m_clr = 1; m_jmp = 0; m_ovr = 0;
      m_s1 = '0; m_s2 = '0; m_h = '0;
    end else begin
      st_e = m_s2[0] & ~m_h[0];
      pa_e = m_s2[1] & ~m_h[1];
      ns = m_st;
      case (m_st)
        0: if (st_e) ns = 1;
        1: if (m_cc == 1) ns = 2;
        2: if (m_s2[3]) ns = 4; else if (pa_e) ns = 3;
        3: if (pa_e) ns = 2;
        4: if (st_e && m_hold == 29) ns = 1;
        default: ns = 0;
      endcase
      if (ns == 1 && m_st != 1) begin
        m_score = 0; m_diff = 60; m_ramp = 0; m_cc = 0;
      end else if (m_st == 1) begin
        m_cc++;
      end
      if (m_st == 2 && ns == 2) begin
        if (m_score < 9999) m_score++;
        if (m_ramp == 49) begin
          m_ramp = 0;
          nd = m_diff - 4;
          m_diff = (nd < 20) ? 20 : nd;
        end else begin
          m_ramp++;
        end
      end
      if (ns == 4 && m_st != 4) begin
        if (m_score > m_hi) m_hi = m_score;
        m_hold = 0;
      end else if (m_st == 4 && m_hold < 29) begin
        m_hold++;
      end
      m_shut = (ns == 0 || ns == 3 || ns == 4);
      m_clr  = (ns == 0 || ns == 1);
      m_ovr  = (ns == 4);
      m_jmp  = m_s2[2] && (ns == 2);
      m_st = ns;
      m_h  = m_s2[1:0];
      m_s2 = m_s1;
      m_s1 = inp;
    end
  endtask

  // Drive one cycle of inputs, predict, then compare after the edge.
  task automatic cyc(input bit rst, input bit st, input bit pa, input bit jm, input bit co);
    exp_t e;
    reset = rst; btn_start = st; btn_pause = pa; btn_jump = jm; collision = co;
    model_step(rst, {co, jm, pa, st});
    e = '{m_st, m_shut, m_clr, m_jmp, m_ovr, m_diff, m_score, m_hi};
    exp_q.push_back(e);
    @(posedge clk_100ms);
    @(negedge clk_100ms);
    e = exp_q.pop_front();
    check("state", 32'(state), 32'(e.st));
    check("shut", 32'(shut), 32'(e.shut));
    check("clr", 32'(clr), 32'(e.clr));
    check("jump_en", 32'(jump_en), 32'(e.jmp));
    check("over", 32'(over), 32'(e.ovr));
    check("diff", 32'(diff), 32'(e.diff));
    check("score", 32'(score), to_bcd(e.score));
    check("hi_score", 32'(hi_score), to_bcd(e.hi));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
  endtask

  // Bounded wait for the model to reach a state, then confirm the DUT agrees.
  task automatic wait_state(input int tgt, input int budget);
    for (int i = 0; i < budget && m_st != tgt; i++) cyc(0, 0, 0, 0, 0);
    check("reach_state", 32'(state), 32'(tgt));
  endtask

  initial begin
    @(negedge clk_100ms);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 1, 1, 1, 1);
    check("rst_state", 32'(state), 0);
    check("rst_shut", 32'(shut), 1);
    check("rst_clr", 32'(clr), 1);
    check("rst_diff", 32'(diff), 60);
    check("rst_score", 32'(score), 0);

    // Start press: CLEAR two edges after sampling, RUN after two CLEAR cycles.
    cyc(0, 1, 0, 0, 0);
    idle(1);
    check("start_k1", 32'(state), 0);
    idle(1);
    check("clear_state", 32'(state), 1);
    check("clear_clr", 32'(clr), 1);
    check("clear_shut", 32'(shut), 0);
    idle(1);
    check("clear_hold", 32'(state), 1);
    idle(1);
    check("run_state", 32'(state), 2);
    check("run_diff", 32'(diff), 60);
    check("run_score", 32'(score), 0);

    // Speed ramp and score over 500 RUN cycles.
    for (int n = 1; n <= 500; n++) begin
      cyc(0, 0, 0, 1'($urandom_range(0, 1)), 0);
      if (n % 50 == 0 && n <= 250) check("ramp_diff", 32'(diff), 32'(60 - 4 * (n / 50)));
    end
    check("ramp_floor", 32'(diff), 20);
    check("score_500", 32'(score), 32'h0500);
    idle(60);
    check("ramp_clamp", 32'(diff), 20);

    // Pause: frozen score, start and collision ignored.
    cyc(0, 0, 1, 0, 0);
    idle(2);
    check("pause_state", 32'(state), 3);
    for (int i = 0; i < 20; i++) begin
      cyc(0, (i == 8), 0, 0, (i >= 5 && i <= 12));
      check("pause_score", 32'(score), 32'h0562);
      check("pause_shut", 32'(shut), 1);
    end
    cyc(0, 0, 1, 0, 0);
    idle(2);
    check("resume_state", 32'(state), 2);
    idle(1);
    check("resume_score", 32'(score), 32'h0563);

    // Collision with pause edge in the same cycle: OVER wins.
    idle(99);
    cyc(0, 0, 1, 0, 1);
    idle(2);
    check("over_state", 32'(state), 4);
    check("over_flag", 32'(over), 1);
    check("over_shut", 32'(shut), 1);
    check("over_hi", 32'(hi_score), 32'h0664);
    for (int i = 1; i <= 37; i++) begin
      cyc(0, (i == 10 || i == 35), 0, 0, 0);
      if (i == 13) check("early_start", 32'(state), 4);
    end
    check("restart_state", 32'(state), 1);
    check("restart_hi", 32'(hi_score), 32'h0664);
    wait_state(2, 10);

    // Second game scores lower: hi_score unchanged.
    for (int i = 0; i < 80; i++) cyc(0, 0, 0, 1'($urandom_range(0, 1)), 0);
    cyc(0, 0, 0, 0, 1);
    wait_state(4, 10);
    check("game2_hi", 32'(hi_score), 32'h0664);
    idle(35);
    cyc(0, 1, 0, 0, 0);
    wait_state(2, 10);

    // Third game runs into score saturation.
    for (int i = 0; i < 10005; i++) cyc(0, 0, 0, 1'($urandom_range(0, 1)), 0);
    check("sat_score", 32'(score), 32'h9999);
    idle(3);
    check("sat_hold", 32'(score), 32'h9999);
    check("sat_diff", 32'(diff), 20);
    check("sat_hi", 32'(hi_score), 32'h0664);

    // Reset mid-RUN returns everything to reset values.
    cyc(1, 0, 0, 1, 0);
    check("mid_rst_state", 32'(state), 0);
    check("mid_rst_shut", 32'(shut), 1);
    check("mid_rst_clr", 32'(clr), 1);
    check("mid_rst_jump", 32'(jump_en), 0);
    check("mid_rst_diff", 32'(diff), 60);
    check("mid_rst_score", 32'(score), 0);
    check("mid_rst_hi", 32'(hi_score), 0);
    check("mid_rst_over", 32'(over), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/game_flow_ctrl.md
# game_flow_ctrl

Top-level game sequencer for the runner game. It turns the player buttons and the renderer's collision flag into the renderer control signals: `shut` (freeze), `clr` (scene reload) and `jump_en`. It also owns the speed-ramp divisor `diff`, which the 0.1 ms game-tick generator consumes. It keeps a 4-digit BCD score and high score for the score overlay, and runs entirely in the 100 ms domain.

## Interface
Clock and reset: reset reset, synchronous, active-high; clock clk_100ms.

Parameters:
- DIFF_INIT, 60: tick divisor loaded at game start.
- DIFF_MIN, 20: fastest divisor; the ramp clamps here.
- DIFF_STEP, 4: divisor decrement per ramp step.
- RAMP_TICKS, 50: RUN cycles per ramp step (5 s).
- CLR_TICKS, 2: cycles `clr` is held in CLEAR.
- OVER_HOLD, 30: OVER cycles before a restart is accepted (3 s).

Ports:
- clk_100ms, in, 1: 100 ms tick clock.
- reset, in, 1: synchronous, active-high.
- btn_start, in, 1: start/restart button, async level.
- btn_pause, in, 1: pause toggle button, async level.
- btn_jump, in, 1: jump button, async level.
- collision, in, 1: renderer collision flag, async level.
- shut, out, 1: freeze scroll, jump physics and animation.
- clr, out, 1: reload scene positions and velocity.
- jump_en, out, 1: gated jump request to the renderer.
- diff, out, 7: game-tick divisor.
- score, out, 16: 4-digit BCD score, `score[15:12]` is the thousands digit.
- hi_score, out, 16: 4-digit BCD best score.
- state, out, 3: FSM state, for debug and LEDs.
- over, out, 1: high in OVER; selects the game-over sprite.

## Operation
- Input conditioning:
  - Every async input passes through a 2-flop synchronizer.
  - `btn_start` and `btn_pause` also get a third history flop; edge = sync & ~hist.
  - The 100 ms sampling is the debounce.
- States: IDLE=0, CLEAR=1, RUN=2, PAUSE=3, OVER=4; values 5–7 go to IDLE.
- IDLE
  - Outputs: shut=1, clr=1.
  - start edge → CLEAR.
- CLEAR
  - Outputs: clr=1, shut=0.
  - On entry: score cleared, `diff`=DIFF_INIT, ramp counter cleared.
  - Stays exactly CLR_TICKS cycles, then → RUN.
- RUN
  - Outputs: shut=0, clr=0.
  - `score` increments once per cycle and saturates at 9999.
  - The ramp counter counts 0..RAMP_TICKS-1. On wrap, `diff` becomes max(diff−DIFF_STEP, DIFF_MIN).
  - Transitions: synced collision=1 → OVER; otherwise pause edge → PAUSE.
- PAUSE
  - Outputs: shut=1.
  - Score, ramp counter and `diff` are frozen.
  - pause edge → RUN. start edge and collision are ignored.
- OVER
  - Outputs: shut=1, over=1.
  - On entry: `hi_score` ← score if score > hi_score (BCD compare, digit-wise from the MSD). Hold counter cleared.
  - The hold counter counts to OVER_HOLD−1 and saturates.
  - start edge with the counter saturated → CLEAR. Earlier start edges are dropped.
- Always: `jump_en` = synced btn_jump AND state==RUN, registered.
- Score arithmetic: per-digit BCD increment, carry rippling within one cycle, saturating at 9999.
- `hi_score` is cleared only by `reset`, never by CLEAR.

## Timing
- Reset values: state=IDLE, shut=1, clr=1, jump_en=0, diff=DIFF_INIT, score=0, hi_score=0, over=0. All counters are 0.
- `reset` overrides every other input in the same edge. Reset mid-game returns to IDLE and clears `hi_score`.
- Latency, input first sampled high at edge k:
  - synced value valid after edge k+1;
  - state/output change registered at edge k+2.
- All outputs are registered. Outputs are decoded from the next state, so they change on the same edge as `state`.
- Simultaneous events in RUN: collision beats pause edge → OVER.
- A held button produces exactly one edge. Re-press requires one sampled-low cycle.
- Ramp wrap on the same cycle as a collision: `diff` update is discarded; OVER keeps the pre-wrap `diff`.
- Score at 9999 stays 9999; the ramp continues.
- `diff` never goes below DIFF_MIN, even if the step overshoots.

## Structure
- Shared package `game_pkg`:
  - state encoding constants;
  - 4-bit BCD digit type;
  - DIFF_INIT, DIFF_MIN and DIFF_STEP defaults, shared with the tick generator.
- One sub-module, `bcd_counter4`: 4-digit saturating BCD counter with `clear` and `inc` inputs. Used for `score`.
- Synchronizers, edge detect, FSM, ramp, hold counter and hi-score compare all live in `game_flow_ctrl`.

## Test plan
- Reset, then press start for 1 cycle:
  - state goes IDLE→CLEAR at edge 2, RUN at edge 4;
  - clr=1 through CLEAR;
  - diff=60, score=0000.
- RUN for 250 cycles:
  - diff steps 56, 52, 48, 44, 40 at cycles 50, 100, 150, 200, 250;
  - after 500 cycles, diff=20 and stays 20;
  - score=0500 BCD at 500 cycles.
- In RUN, press pause:
  - shut=1 and score frozen for 20 cycles;
  - second press resumes, score continues from the frozen value;
  - collision asserted during PAUSE is ignored.
- Collision with a pause edge in the same cycle:
  - state → OVER, over=1, shut=1;
  - hi_score = score;
  - start at hold cycle 10 is ignored; start after cycle 30 → CLEAR;
  - hi_score is kept.
- Force score to 9998 and run 3 cycles: score goes 9999, 9999, 9999.
- Second game scoring lower than hi_score: hi_score unchanged. Assert reset mid-RUN: all outputs return to reset values on the next edge.
